// File: rtl/cpu_pkg.sv
// Shared opcode, ALU-select and state definitions for the control unit.
// MULDIV_EN (see instr_decode) decides whether the mul/div opcodes are live.
package cpu_pkg;

  localparam logic [4:0] OP_LD   = 5'b00000;
  localparam logic [4:0] OP_LDI  = 5'b00001;
  localparam logic [4:0] OP_ST   = 5'b00010;
  localparam logic [4:0] OP_ADD  = 5'b00011;
  localparam logic [4:0] OP_SUB  = 5'b00100;
  localparam logic [4:0] OP_AND  = 5'b00101;
  localparam logic [4:0] OP_OR   = 5'b00110;
  localparam logic [4:0] OP_ADDI = 5'b01100;
  localparam logic [4:0] OP_ANDI = 5'b01101;
  localparam logic [4:0] OP_ORI  = 5'b01110;
  localparam logic [4:0] OP_MUL  = 5'b01111;
  localparam logic [4:0] OP_DIV  = 5'b10000;
  localparam logic [4:0] OP_BR   = 5'b10011;
  localparam logic [4:0] OP_JR   = 5'b10100;
  localparam logic [4:0] OP_IN   = 5'b10110;
  localparam logic [4:0] OP_OUT  = 5'b10111;
  localparam logic [4:0] OP_MFHI = 5'b11000;
  localparam logic [4:0] OP_MFLO = 5'b11001;
  localparam logic [4:0] OP_NOP  = 5'b11010;
  localparam logic [4:0] OP_HALT = 5'b11011;

  localparam logic [4:0] ALU_NONE   = 5'b00000;
  localparam logic [4:0] ALU_ADD    = 5'b00011;
  localparam logic [4:0] ALU_AND    = 5'b00101;
  localparam logic [4:0] ALU_OR     = 5'b00110;
  localparam logic [4:0] ALU_INC_PC = 5'b11111;

  typedef enum logic [3:0] {
    S_RESET, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_T7, S_HALT
  } state_t;

  typedef enum logic [3:0] {
    C_NOP, C_RTYPE, C_IMM, C_LD, C_LDI, C_ST, C_BR, C_JR,
    C_IN, C_OUT, C_MFHI, C_MFLO, C_HALT, C_MULDIV
  } iclass_t;

endpackage

// File: rtl/instr_decode.sv
// Combinational IR -> instruction-class decode plus the ALU select for the op.
// Build option MULDIV_EN: when undefined, mul/div decode as nop.
module instr_decode
  import cpu_pkg::*;
(
  input  logic [31:0] ir,
  output logic [3:0]  iclass,
  output logic [4:0]  alu_code
);

  logic [4:0] opcode;
  logic       unused_ir;

  assign opcode    = ir[31:27];
  // Register and constant fields are consumed by the datapath, not here.
  assign unused_ir = ^ir[26:0];

  always_comb begin
    iclass   = C_NOP;
    alu_code = ALU_NONE;
    case (opcode)
      OP_ADD, OP_SUB, OP_AND, OP_OR: begin
        iclass   = C_RTYPE;
        alu_code = opcode;
      end
      OP_ADDI: begin iclass = C_IMM; alu_code = ALU_ADD; end
      OP_ANDI: begin iclass = C_IMM; alu_code = ALU_AND; end
      OP_ORI:  begin iclass = C_IMM; alu_code = ALU_OR;  end
      OP_LD:   begin iclass = C_LD;  alu_code = ALU_ADD; end
      OP_LDI:  begin iclass = C_LDI; alu_code = ALU_ADD; end
      OP_ST:   begin iclass = C_ST;  alu_code = ALU_ADD; end
      OP_BR:   begin iclass = C_BR;  alu_code = ALU_ADD; end
      OP_JR:   iclass = C_JR;
      OP_IN:   iclass = C_IN;
      OP_OUT:  iclass = C_OUT;
      OP_MFHI: iclass = C_MFHI;
      OP_MFLO: iclass = C_MFLO;
      OP_HALT: iclass = C_HALT;
`ifdef MULDIV_EN
      OP_MUL, OP_DIV: begin
        iclass   = C_MULDIV;
        alu_code = opcode;
      end
`endif
      default: iclass = C_NOP;
    endcase
  end

endmodule

// File: rtl/control_unit.sv
// Moore sequencer for the multi-cycle CPU: RESET, fetch T0-T2, execute T3-T7, HALT.
// Build option MULDIV_EN enables the mul/div execute sequence (decoded in instr_decode).
module control_unit
  import cpu_pkg::*;
(
  input  logic        clock,
  input  logic        clear,
  input  logic [31:0] IR,
  input  logic        ConOut,
  input  logic        Stop,
  output logic        HiIn,
  output logic        LoIn,
  output logic        ZIn,
  output logic        PCIn,
  output logic        MDRIn,
  output logic        MARIn,
  output logic        YIn,
  output logic        OPortIn,
  output logic        IRIn,
  output logic        HiOut,
  output logic        LoOut,
  output logic        ZHiOut,
  output logic        ZLoOut,
  output logic        PCOut,
  output logic        MDROut,
  output logic        IPortOut,
  output logic        COut,
  output logic        Gra,
  output logic        Grb,
  output logic        Grc,
  output logic        RIn,
  output logic        ROut,
  output logic        BAOut,
  output logic        Conin,
  output logic        memread,
  output logic        memwrite,
  output logic [4:0]  ALUCode,
  output logic        Run
);

  state_t     state;
  iclass_t    cls;
  logic [3:0] cls_raw;
  logic [4:0] op_alu;
  logic       is_last;

  instr_decode u_decode (
    .ir       (IR),
    .iclass   (cls_raw),
    .alu_code (op_alu)
  );

  assign cls = iclass_t'(cls_raw);

  // The nop decision at T2 relies on IR already presenting the incoming
  // instruction during T2; all later states see the latched IR.
  always_comb begin
    is_last = 1'b0;
    case (state)
      S_T2:    is_last = (cls == C_NOP);
      S_T3:    is_last = !(cls inside {C_RTYPE, C_IMM, C_LD, C_LDI, C_ST, C_BR, C_MULDIV});
      S_T5:    is_last = !(cls inside {C_LD, C_ST, C_BR, C_MULDIV});
      S_T6:    is_last = (cls != C_LD);
      S_T7:    is_last = 1'b1;
      default: is_last = 1'b0;
    endcase
  end

  always_ff @(posedge clock) begin
    if (clear) begin
      state <= S_RESET;
    end else begin
      case (state)
        S_RESET: state <= S_T0;
        S_HALT:  state <= S_HALT;
        default: begin
          if (is_last)
            state <= (Stop || (state == S_T3 && cls == C_HALT)) ? S_HALT : S_T0;
          else
            state <= state_t'(state + 4'd1);
        end
      endcase
    end
  end

  assign Run = (state != S_RESET) && (state != S_HALT);

  always_comb begin
    {HiIn, LoIn, ZIn, PCIn, MDRIn, MARIn, YIn, OPortIn, IRIn,
     HiOut, LoOut, ZHiOut, ZLoOut, PCOut, MDROut, IPortOut, COut,
     Gra, Grb, Grc, RIn, ROut, BAOut, Conin, memread, memwrite} = 26'd0;
    ALUCode = ALU_NONE;
    case (state)
      S_T0: begin PCOut = 1'b1; MARIn = 1'b1; ZIn = 1'b1; ALUCode = ALU_INC_PC; end
      S_T1: begin ZLoOut = 1'b1; PCIn = 1'b1; memread = 1'b1; MDRIn = 1'b1; end
      S_T2: begin MDROut = 1'b1; IRIn = 1'b1; end
      S_T3: begin
        case (cls)
          C_RTYPE, C_IMM: begin Grb = 1'b1; ROut = 1'b1; YIn = 1'b1; end
          C_LD, C_LDI, C_ST: begin Grb = 1'b1; BAOut = 1'b1; YIn = 1'b1; end
          C_BR:     begin Gra = 1'b1; ROut = 1'b1; Conin = 1'b1; end
          C_JR:     begin Gra = 1'b1; ROut = 1'b1; PCIn = 1'b1; end
          C_IN:     begin IPortOut = 1'b1; Gra = 1'b1; RIn = 1'b1; end
          C_OUT:    begin Gra = 1'b1; ROut = 1'b1; OPortIn = 1'b1; end
          C_MFHI:   begin HiOut = 1'b1; Gra = 1'b1; RIn = 1'b1; end
          C_MFLO:   begin LoOut = 1'b1; Gra = 1'b1; RIn = 1'b1; end
          C_MULDIV: begin Gra = 1'b1; ROut = 1'b1; YIn = 1'b1; end
          default: ;
        endcase
      end
      S_T4: begin
        case (cls)
          C_RTYPE: begin Grc = 1'b1; ROut = 1'b1; ZIn = 1'b1; ALUCode = op_alu; end
          C_IMM, C_LD, C_LDI, C_ST: begin COut = 1'b1; ZIn = 1'b1; ALUCode = op_alu; end
          C_BR:     begin PCOut = 1'b1; YIn = 1'b1; end
          C_MULDIV: begin Grb = 1'b1; ROut = 1'b1; ZIn = 1'b1; ALUCode = op_alu; end
          default: ;
        endcase
      end
      S_T5: begin
        case (cls)
          C_RTYPE, C_IMM, C_LDI: begin ZLoOut = 1'b1; Gra = 1'b1; RIn = 1'b1; end
          C_LD, C_ST: begin ZLoOut = 1'b1; MARIn = 1'b1; end
          C_BR:     begin COut = 1'b1; ZIn = 1'b1; ALUCode = ALU_ADD; end
          C_MULDIV: begin ZLoOut = 1'b1; LoIn = 1'b1; end
          default: ;
        endcase
      end
      S_T6: begin
        case (cls)
          C_LD:     begin memread = 1'b1; MDRIn = 1'b1; end
          C_ST:     begin memwrite = 1'b1; Gra = 1'b1; ROut = 1'b1; end
          C_BR:     begin ZLoOut = ConOut; PCIn = ConOut; end
          C_MULDIV: begin ZHiOut = 1'b1; HiIn = 1'b1; end
          default: ;
        endcase
      end
      S_T7: begin
        if (cls == C_LD) begin MDROut = 1'b1; Gra = 1'b1; RIn = 1'b1; end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_control_unit.sv
// Scoreboard bench for control_unit: stimulus queues per-cycle expected strobes,
// a negedge monitor pops and compares. MULDIV_EN selects the mul expectations.
module tb_control_unit;

  logic        clock = 1'b0;
  logic        clear, ConOut, Stop;
  logic [31:0] IR;
  logic HiIn, LoIn, ZIn, PCIn, MDRIn, MARIn, YIn, OPortIn, IRIn;
  logic HiOut, LoOut, ZHiOut, ZLoOut, PCOut, MDROut, IPortOut, COut;
  logic Gra, Grb, Grc, RIn, ROut, BAOut, Conin, memread, memwrite, Run;
  logic [4:0] ALUCode;

  always #5 clock = ~clock;

  control_unit dut (
    .clock(clock), .clear(clear), .IR(IR), .ConOut(ConOut), .Stop(Stop),
    .HiIn(HiIn), .LoIn(LoIn), .ZIn(ZIn), .PCIn(PCIn), .MDRIn(MDRIn),
    .MARIn(MARIn), .YIn(YIn), .OPortIn(OPortIn), .IRIn(IRIn),
    .HiOut(HiOut), .LoOut(LoOut), .ZHiOut(ZHiOut), .ZLoOut(ZLoOut),
    .PCOut(PCOut), .MDROut(MDROut), .IPortOut(IPortOut), .COut(COut),
    .Gra(Gra), .Grb(Grb), .Grc(Grc), .RIn(RIn), .ROut(ROut), .BAOut(BAOut),
    .Conin(Conin), .memread(memread), .memwrite(memwrite),
    .ALUCode(ALUCode), .Run(Run)
  );

  logic [31:0] obs;
  assign obs = {Run, ALUCode, memwrite, memread, Conin, BAOut, ROut, RIn, Grc, Grb, Gra,
                COut, IPortOut, MDROut, PCOut, ZLoOut, ZHiOut, LoOut, HiOut,
                IRIn, OPortIn, YIn, MARIn, MDRIn, PCIn, ZIn, LoIn, HiIn};

  localparam logic [31:0] M_HIIN = 32'd1 << 0,  M_LOIN = 32'd1 << 1,  M_ZIN = 32'd1 << 2;
  localparam logic [31:0] M_PCIN = 32'd1 << 3,  M_MDRIN = 32'd1 << 4, M_MARIN = 32'd1 << 5;
  localparam logic [31:0] M_YIN = 32'd1 << 6,   M_OPORTIN = 32'd1 << 7, M_IRIN = 32'd1 << 8;
  localparam logic [31:0] M_HIOUT = 32'd1 << 9, M_LOOUT = 32'd1 << 10, M_ZHIOUT = 32'd1 << 11;
  localparam logic [31:0] M_ZLOOUT = 32'd1 << 12, M_PCOUT = 32'd1 << 13, M_MDROUT = 32'd1 << 14;
  localparam logic [31:0] M_IPORTOUT = 32'd1 << 15, M_COUT = 32'd1 << 16, M_GRA = 32'd1 << 17;
  localparam logic [31:0] M_GRB = 32'd1 << 18, M_GRC = 32'd1 << 19, M_RIN = 32'd1 << 20;
  localparam logic [31:0] M_ROUT = 32'd1 << 21, M_BAOUT = 32'd1 << 22, M_CONIN = 32'd1 << 23;
  localparam logic [31:0] M_MEMREAD = 32'd1 << 24, M_MEMWRITE = 32'd1 << 25, M_RUN = 32'd1 << 31;

  function automatic logic [31:0] alu(input logic [4:0] c);
    return {1'b0, c, 26'd0};
  endfunction

  typedef struct {
    string       name;
    logic [31:0] exp;
  } exp_t;

  exp_t sb[$];
  exp_t cur;
  int   checks = 0;
  int   passes = 0;

  task automatic step(input string name, input logic [31:0] e);
    sb.push_back('{name: name, exp: e});
    @(posedge clock);
    #1;
  endtask

  task automatic fetch(input string name);
    step({name, ".T0"}, M_RUN | M_PCOUT | M_MARIN | M_ZIN | alu(5'b11111));
    step({name, ".T1"}, M_RUN | M_ZLOOUT | M_PCIN | M_MEMREAD | M_MDRIN);
    step({name, ".T2"}, M_RUN | M_MDROUT | M_IRIN);
  endtask

  task automatic hold_halt(input string name);
    for (int i = 0; i < 10; i++) step(name, 32'd0);
    clear = 1'b1;
    step({name, ".clr"}, 32'd0);
    clear = 1'b0;
    step({name, ".reset"}, 32'd0);
  endtask

  initial begin
    forever begin
      @(negedge clock);
      if (sb.size() > 0) begin
        cur = sb.pop_front();
        checks++;
        if (obs === cur.exp) passes++;
        else $display("FAIL %s: got %h expected %h", cur.name, obs, cur.exp);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d so far", passes, checks);
    $fatal(1);
  end

  initial begin
    clear = 1'b1; Stop = 1'b0; ConOut = 1'b0; IR = 32'd0;
    @(posedge clock); #1;
    step("reset.held", 32'd0);
    clear = 1'b0;
    step("reset.release", 32'd0);

    // ld r2, 0x95(r3)
    IR = {5'b00000, 4'd2, 4'd3, 19'h95};
    fetch("ld");
    step("ld.T3", M_RUN | M_GRB | M_BAOUT | M_YIN);
    step("ld.T4", M_RUN | M_COUT | M_ZIN | alu(5'b00011));
    step("ld.T5", M_RUN | M_ZLOOUT | M_MARIN);
    step("ld.T6", M_RUN | M_MEMREAD | M_MDRIN);
    step("ld.T7", M_RUN | M_MDROUT | M_GRA | M_RIN);

    // st 0x87(r0), r3
    IR = {5'b00010, 4'd3, 4'd0, 19'h87};
    fetch("st");
    step("st.T3", M_RUN | M_GRB | M_BAOUT | M_YIN);
    step("st.T4", M_RUN | M_COUT | M_ZIN | alu(5'b00011));
    step("st.T5", M_RUN | M_ZLOOUT | M_MARIN);
    step("st.T6", M_RUN | M_MEMWRITE | M_GRA | M_ROUT);

    IR = {5'b00001, 4'd4, 4'd0, 19'h12};
    fetch("ldi");
    step("ldi.T3", M_RUN | M_GRB | M_BAOUT | M_YIN);
    step("ldi.T4", M_RUN | M_COUT | M_ZIN | alu(5'b00011));
    step("ldi.T5", M_RUN | M_ZLOOUT | M_GRA | M_RIN);

    IR = {5'b00100, 4'd1, 4'd2, 4'd3, 15'd0};
    fetch("sub");
    step("sub.T3", M_RUN | M_GRB | M_ROUT | M_YIN);
    step("sub.T4", M_RUN | M_GRC | M_ROUT | M_ZIN | alu(5'b00100));
    step("sub.T5", M_RUN | M_ZLOOUT | M_GRA | M_RIN);

    IR = {5'b01110, 4'd5, 4'd6, 19'h3};
    fetch("ori");
    step("ori.T3", M_RUN | M_GRB | M_ROUT | M_YIN);
    step("ori.T4", M_RUN | M_COUT | M_ZIN | alu(5'b00110));
    step("ori.T5", M_RUN | M_ZLOOUT | M_GRA | M_RIN);

    for (int c = 0; c < 2; c++) begin
      IR = {5'b10011, 4'd6, 4'd2, 19'h19};
      ConOut = (c == 1);
      fetch("br");
      step("br.T3", M_RUN | M_GRA | M_ROUT | M_CONIN);
      step("br.T4", M_RUN | M_PCOUT | M_YIN);
      step("br.T5", M_RUN | M_COUT | M_ZIN | alu(5'b00011));
      step(c == 1 ? "br.T6.taken" : "br.T6.not_taken",
           c == 1 ? (M_RUN | M_ZLOOUT | M_PCIN) : M_RUN);
      ConOut = 1'b0;
    end

    IR = {5'b10100, 4'd7, 23'd0};
    fetch("jr");
    step("jr.T3", M_RUN | M_GRA | M_ROUT | M_PCIN);
    IR = {5'b10110, 4'd3, 23'd0};
    fetch("in");
    step("in.T3", M_RUN | M_IPORTOUT | M_GRA | M_RIN);
    IR = {5'b10111, 4'd3, 23'd0};
    fetch("out");
    step("out.T3", M_RUN | M_GRA | M_ROUT | M_OPORTIN);
    IR = {5'b11000, 4'd8, 23'd0};
    fetch("mfhi");
    step("mfhi.T3", M_RUN | M_HIOUT | M_GRA | M_RIN);
    IR = {5'b11001, 4'd9, 23'd0};
    fetch("mflo");
    step("mflo.T3", M_RUN | M_LOOUT | M_GRA | M_RIN);

    // nop and an unassigned opcode end after T2
    IR = {5'b11010, 27'd0};
    fetch("nop");
    IR = {5'b11111, 27'h7ffffff};
    fetch("unassigned");

    IR = {5'b01111, 4'd1, 4'd2, 19'd0};
    fetch("mul");
`ifdef MULDIV_EN
    step("mul.T3", M_RUN | M_GRA | M_ROUT | M_YIN);
    step("mul.T4", M_RUN | M_GRB | M_ROUT | M_ZIN | alu(5'b01111));
    step("mul.T5", M_RUN | M_ZLOOUT | M_LOIN);
    step("mul.T6", M_RUN | M_ZHIOUT | M_HIIN);
`endif

    // clear during T4 of an add
    IR = {5'b00011, 4'd1, 4'd2, 4'd3, 15'd0};
    fetch("add");
    step("add.T3", M_RUN | M_GRB | M_ROUT | M_YIN);
    clear = 1'b1;
    step("add.T4", M_RUN | M_GRC | M_ROUT | M_ZIN | alu(5'b00011));
    clear = 1'b0;
    step("add.clr.reset", 32'd0);

    IR = {5'b11011, 27'd0};
    fetch("halt");
    step("halt.T3", M_RUN);
    hold_halt("halt.hold");

    // Stop raised in the last state of an addi
    IR = {5'b01100, 4'd2, 4'd3, 19'h5};
    fetch("addi");
    step("addi.T3", M_RUN | M_GRB | M_ROUT | M_YIN);
    step("addi.T4", M_RUN | M_COUT | M_ZIN | alu(5'b00011));
    Stop = 1'b1;
    step("addi.T5", M_RUN | M_ZLOOUT | M_GRA | M_RIN);
    Stop = 1'b0;
    hold_halt("stop.hold");

    fetch("after_halt");

    for (int i = 0; i < 20 && sb.size() > 0; i++) @(negedge clock);
    if (sb.size() > 0) begin
      checks++;
      $display("FAIL drain: got %0d pending expected 0", sb.size());
    end
    #1;
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/control_unit.md
CONTROL_UNIT -- requirements
Module: control_unit

Interface
REQ-001 clock  input  1  system clock; all state changes on rising edge.
REQ-002 clear  input  1  synchronous, active-high reset.
REQ-003 IR  input  32  current instruction; opcode IR[31:27], Ra IR[26:23], Rb IR[22:19], Rc IR[18:15], C IR[18:0].
REQ-004 ConOut  input  1  branch-condition flag from the datapath.
REQ-005 Stop  input  1  halt request, sampled at instruction end.
REQ-006 HiIn, LoIn, ZIn, PCIn, MDRIn, MARIn, YIn, OPortIn, IRIn  output  1 each  register load strobes.
REQ-007 HiOut, LoOut, ZHiOut, ZLoOut, PCOut, MDROut, IPortOut, COut  output  1 each  bus drive strobes.
REQ-008 Gra, Grb, Grc, RIn, ROut, BAOut, Conin  output  1 each  register-file select, register-file strobes and condition-latch strobe.
REQ-009 memread, memwrite  output  1 each  single-cycle memory strobes.
REQ-010 ALUCode  output  5  ALU operation select; 5'b00000 when idle.
REQ-011 Run  output  1  high while executing; low in RESET and HALT.

Function
REQ-012 Moore FSM with states RESET, T0–T7 and HALT; each state lasts exactly one clock; outputs decode from the state register and IR only.
REQ-013 Unlisted strobes are 0 in every state; ALUCode is 0 unless stated otherwise.
REQ-014 RESET→T0 unconditionally.
REQ-015 Fetch: T0 PCOut, MARIn, ZIn, ALUCode=INC_PC (5'b11111); T1 ZLoOut, PCIn, memread, MDRIn; T2 MDROut, IRIn.
REQ-016 T3 onward decode the IR value latched at T2 end.
REQ-017 add/sub/and/or (R-type): T3 Grb,ROut,YIn; T4 Grc,ROut,ZIn, ALUCode=opcode; T5 ZLoOut,Gra,RIn.
REQ-018 addi/andi/ori: as R-type, but T4 uses COut, with ALUCode=ADD(00011)/AND(00101)/OR(00110).
REQ-019 ld: T3 Grb,BAOut,YIn; T4 COut,ZIn,ALUCode=ADD; T5 ZLoOut,MARIn; T6 memread,MDRIn; T7 MDROut,Gra,RIn.
REQ-020 ldi: T3–T4 as ld; T5 ZLoOut,Gra,RIn.
REQ-021 st: T3–T5 as ld; T6 memwrite,Gra,ROut.
REQ-022 br: T3 Gra,ROut,Conin; T4 PCOut,YIn; T5 COut,ZIn,ALUCode=ADD; T6 ZLoOut and PCIn only if ConOut=1, otherwise no strobes.
REQ-023 jr: T3 Gra,ROut,PCIn.
REQ-024 in: T3 IPortOut,Gra,RIn. out: T3 Gra,ROut,OPortIn. mfhi: T3 HiOut,Gra,RIn. mflo: T3 LoOut,Gra,RIn.
REQ-025 nop and any unassigned opcode end after T2.
REQ-026 halt: T3 no strobes, then HALT.
REQ-027 After an instruction's last state: next state is HALT if Stop=1, else T0.
REQ-028 HALT holds, with all strobes 0 and Run=0, until clear.

Reset
REQ-029 clear=1 at a rising edge forces RESET from any state, including mid-instruction.
REQ-030 In RESET, all outputs are 0; no partial memwrite or RIn occurs after the clear edge.

Configuration
REQ-031 Macro MULDIV_EN defined: mul(01111)/div(10000) execute T3 Gra,ROut,YIn; T4 Grb,ROut,ZIn,ALUCode=opcode; T5 ZLoOut,LoIn; T6 ZHiOut,HiIn.
REQ-032 Macro MULDIV_EN undefined: mul/div behave as nop, and HiIn/LoIn stay 0.

Structure
REQ-033 Shared package cpu_pkg holds the opcode constants, the ALUCode constants (ADD, AND, OR, INC_PC) and the state enum.
REQ-034 Sub-module instr_decode: combinational IR→instruction-class decode, kept separate from the sequencer.

Verification
REQ-035 ld, IR={00000,Ra=2,Rb=3,C=0x95}: T0–T7 strobes per REQ-015/019, with ALUCode 11111 at T0 and 00011 at T4.
REQ-036 st, IR={00010,Ra=3,Rb=0,C=0x87}: memwrite high only in T6, together with Gra and ROut; next state T0.
REQ-037 br with ConOut=0 and then with ConOut=1: PCIn asserts in T6 only in the ConOut=1 case.
REQ-038 clear asserted in T4 of an add: next cycle is RESET with all outputs 0; T0 follows one cycle later.
REQ-039 halt instruction, and separately Stop=1 during the T5 of an addi: Run falls and the FSM stays in HALT for 10 cycles.
REQ-040 mul with MULDIV_EN defined and undefined: LoIn/HiIn in T5/T6 versus none.
